fb_rect_fill: RTL and testbench



---
 rtl/fb_rect_fill.sv | 149 ++++++++++++++
 tb/tb_fb_rect_fill.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine driving framebuffer RAM port A, one pixel per clock in row-major order.
// Optional FB_RECT_CLIP_EN: clamp coordinates to the screen instead of rejecting out-of-range commands.
module fb_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [9:0]    x0,
    input  logic [9:0]    x1,
    input  logic [8:0]    y0,
    input  logic [8:0]    y1,
    input  logic [DW-1:0] color,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [9:0]    X_MAX  = 10'(H_RES - 1);
    localparam logic [8:0]    Y_MAX  = 9'(V_RES - 1);
    localparam logic [AW-1:0] H_STEP = AW'(H_RES);

    logic [1:0]    state;
    logic [9:0]    x_lo, x_hi, x_cur;
    logic [8:0]    y_lo, y_hi, y_cur;
    logic [AW-1:0] base;
    logic [DW-1:0] color_r;

    logic [9:0] cx0, cx1;
    logic [8:0] cy0, cy1;
    logic       range_bad, reject;

    // Row base as a sum of shifted copies of y, one per set bit of H_RES (640 = 512 + 128).
    function automatic logic [AW-1:0] row_base(input logic [8:0] y);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (H_RES[i]) acc = acc + (AW'(y) << i);
        end
        return acc;
    endfunction

    always_comb begin
`ifdef FB_RECT_CLIP_EN
        cx0       = (x0 > X_MAX) ? X_MAX : x0;
        cx1       = (x1 > X_MAX) ? X_MAX : x1;
        cy0       = (y0 > Y_MAX) ? Y_MAX : y0;
        cy1       = (y1 > Y_MAX) ? Y_MAX : y1;
        range_bad = 1'b0;
`else
        cx0       = x0;
        cx1       = x1;
        cy0       = y0;
        cy1       = y1;
        range_bad = (x0 > X_MAX) || (x1 > X_MAX) || (y0 > Y_MAX) || (y1 > Y_MAX);
`endif
        reject = range_bad || (cx0 > cx1) || (cy0 > cy1);
    end

    // addra always holds the address of the write presented this cycle, so FILL advances it one step ahead.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            x_lo      <= '0;
            x_hi      <= '0;
            x_cur     <= '0;
            y_lo      <= '0;
            y_hi      <= '0;
            y_cur     <= '0;
            base      <= '0;
            color_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        x_lo      <= cx0;
                        x_hi      <= cx1;
                        y_lo      <= cy0;
                        y_hi      <= cy1;
                        color_r   <= color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (reject) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    base  <= row_base(y_lo);
                    x_cur <= x_lo;
                    y_cur <= y_lo;
                    addra <= row_base(y_lo) + AW'(x_lo);
                    dina  <= color_r;
                    wea   <= 1'b1;
                    state <= S_FILL;
                end
                S_FILL: begin
                    if (x_cur == x_hi) begin
                        if (y_cur == y_hi) begin
                            wea   <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            x_cur <= x_lo;
                            y_cur <= y_cur + 9'd1;
                            base  <= base + H_STEP;
                            addra <= base + H_STEP + AW'(x_lo);
                        end
                    end else begin
                        x_cur <= x_cur + 10'd1;
                        addra <= addra + AW'(1);
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed corner cases plus random rectangles against a loop-based model.
// Also models the shared RAM so filled pixels can be read back through a registered port B.
module tb_fb_rect_fill;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int WORDS = H_RES * V_RES;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  x0 = '0, x1 = '0;
    logic [8:0]  y0 = '0, y1 = '0;
    logic [15:0] color = '0;
    logic        busy, done, err, wea;
    logic [18:0] addra;
    logic [15:0] dina;

    int checks = 0;
    int failures = 0;

    fb_rect_fill #(.H_RES(H_RES), .V_RES(V_RES), .AW(19), .DW(16)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .busy(busy), .done(done), .err(err),
        .wea(wea), .addra(addra), .dina(dina)
    );

    always #5 clk = ~clk;

    // Shared framebuffer RAM: port A written by the DUT, port B read by the bench.
    logic [15:0] fb [0:WORDS-1];
    logic [18:0] addrb = '0;
    logic [15:0] doutb;
    always @(posedge clk) begin
        if (wea && (int'(addra) < WORDS)) fb[addra] <= dina;
        doutb <= fb[addrb];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Observations of one command, cycle k meaning k cycles after the accept edge.
    int          obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cyc, done_count;
    logic        done_err, ready_at_done, ready_after, busy_first;

    // Expectations from the reference model.
    int exp_addr[$];
    bit exp_rej;

    task automatic model(input int ax0, input int ax1, input int ay0, input int ay1);
        int cx0, cx1, cy0, cy1;
        cx0 = ax0; cx1 = ax1; cy0 = ay0; cy1 = ay1;
        exp_rej = 0;
`ifdef FB_RECT_CLIP_EN
        if (cx0 > H_RES - 1) cx0 = H_RES - 1;
        if (cx1 > H_RES - 1) cx1 = H_RES - 1;
        if (cy0 > V_RES - 1) cy0 = V_RES - 1;
        if (cy1 > V_RES - 1) cy1 = V_RES - 1;
`else
        if (ax0 >= H_RES || ax1 >= H_RES || ay0 >= V_RES || ay1 >= V_RES) exp_rej = 1;
`endif
        if (cx0 > cx1 || cy0 > cy1) exp_rej = 1;
        exp_addr.delete();
        if (!exp_rej)
            for (int y = cy0; y <= cy1; y++)
                for (int x = cx0; x <= cx1; x++)
                    exp_addr.push_back(y * H_RES + x);
    endtask

    task automatic send_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                            input logic [15:0] acol);
        for (int i = 0; i < 1000 && cmd_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        x0 = 10'(ax0); x1 = 10'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
        color = acol;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        x0 = 10'($urandom); x1 = 10'($urandom);
        y0 = 9'($urandom);  y1 = 9'($urandom);
        color = 16'($urandom);
    endtask

    task automatic collect(input int budget);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cyc = -1; done_count = 0;
        done_err = 1'bx; ready_at_done = 1'bx; ready_after = 1'bx; busy_first = 1'bx;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) busy_first = busy;
            if (wea === 1'b1) begin
                obs_addr.push_back(int'(addra));
                obs_data.push_back(dina);
                obs_cyc.push_back(k);
            end
            if (done === 1'b1) begin
                done_count++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    done_err = err;
                    ready_at_done = cmd_ready;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                ready_after = cmd_ready;
                break;
            end
        end
    endtask

    task automatic read_b(input int a, output logic [15:0] d);
        @(negedge clk);
        addrb = 19'(a);
        @(posedge clk);
        @(negedge clk);
        d = doutb;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        checks++; if (wea !== 1'b0) begin failures++; $display("[TB] FAIL reset_wea got=%b want=0", wea); end
        checks++; if (addra !== 19'd0) begin failures++; $display("[TB] FAIL reset_addra got=%0d want=0", addra); end
        checks++; if (dina !== 16'd0) begin failures++; $display("[TB] FAIL reset_dina got=%h want=0", dina); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pixel;
        send_cmd(5, 5, 3, 3, 16'hF800);
        collect(20);
        checks++; if (busy_first !== 1'b1) begin failures++; $display("[TB] FAIL px_busy_setup got=%b want=1", busy_first); end
        checks++; if (obs_addr.size() != 1) begin failures++; $display("[TB] FAIL px_count got=%0d want=1", obs_addr.size()); end
        if (obs_addr.size() >= 1) begin
            checks++; if (obs_addr[0] !== 1925) begin failures++; $display("[TB] FAIL px_addr got=%0d want=1925", obs_addr[0]); end
            checks++; if (obs_data[0] !== 16'hF800) begin failures++; $display("[TB] FAIL px_data got=%h want=f800", obs_data[0]); end
            checks++; if (obs_cyc[0] !== 2) begin failures++; $display("[TB] FAIL px_cycle got=%0d want=2", obs_cyc[0]); end
        end
        checks++; if (done_cyc !== 3) begin failures++; $display("[TB] FAIL px_done_cycle got=%0d want=3", done_cyc); end
        checks++; if (done_err !== 1'b0) begin failures++; $display("[TB] FAIL px_err got=%b want=0", done_err); end
        checks++; if (ready_at_done !== 1'b0) begin failures++; $display("[TB] FAIL px_ready_in_done got=%b want=0", ready_at_done); end
        checks++; if (done_count !== 1) begin failures++; $display("[TB] FAIL px_done_width got=%0d want=1", done_count); end
        checks++; if (ready_after !== 1'b1) begin failures++; $display("[TB] FAIL px_ready_after got=%b want=1", ready_after); end
    endtask

    task automatic test_row_wrap;
        int want_addr[4];
        logic [15:0] d;
        want_addr = '{638, 639, 1278, 1279};
        send_cmd(638, 639, 0, 1, 16'h07E0);
        collect(30);
        checks++; if (obs_addr.size() != 4) begin failures++; $display("[TB] FAIL wrap_count got=%0d want=4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== want_addr[i] || obs_data[i] !== 16'h07E0 || obs_cyc[i] !== i + 2) begin
                failures++;
                $display("[TB] FAIL wrap_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=07e0 cyc=%0d",
                         i, obs_addr[i], obs_data[i], obs_cyc[i], want_addr[i], i + 2);
            end
        end
        checks++; if (done_cyc !== 6) begin failures++; $display("[TB] FAIL wrap_done_cycle got=%0d want=6", done_cyc); end
        for (int i = 0; i < 4; i++) begin
            read_b(want_addr[i], d);
            checks++; if (d !== 16'h07E0) begin failures++; $display("[TB] FAIL wrap_readback[%0d] got=%h want=07e0", want_addr[i], d); end
        end
    endtask

    task automatic test_corner_block;
        logic [15:0] col, d;
        int exp_done;
        col = 16'($urandom);
        model(600, 639, 470, 479);
        exp_done = 2 + exp_addr.size();
        send_cmd(600, 639, 470, 479, col);
        collect(exp_done + 10);
        checks++; if (obs_addr.size() != exp_addr.size()) begin failures++; $display("[TB] FAIL corner_count got=%0d want=%0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== col || obs_cyc[i] !== i + 2) begin
                failures++;
                $display("[TB] FAIL corner_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], col, i + 2);
            end
        end
        checks++; if (done_cyc !== exp_done) begin failures++; $display("[TB] FAIL corner_done_cycle got=%0d want=%0d", done_cyc, exp_done); end
        read_b(WORDS - 1, d);
        checks++; if (d !== col) begin failures++; $display("[TB] FAIL corner_readback_last got=%h want=%h", d, col); end
    endtask

    task automatic test_reject;
        send_cmd(10, 9, 4, 4, 16'h1111);
        collect(10);
        checks++; if (obs_addr.size() != 0) begin failures++; $display("[TB] FAIL degen_writes got=%0d want=0", obs_addr.size()); end
        checks++; if (done_cyc !== 1) begin failures++; $display("[TB] FAIL degen_done_cycle got=%0d want=1", done_cyc); end
        checks++; if (done_err !== 1'b1) begin failures++; $display("[TB] FAIL degen_err got=%b want=1", done_err); end
        model(639, 700, 4, 4);
        send_cmd(639, 700, 4, 4, 16'h2222);
        collect(20);
        checks++; if (done_err !== exp_rej) begin failures++; $display("[TB] FAIL oor_err got=%b want=%b", done_err, exp_rej); end
        checks++; if (obs_addr.size() != exp_addr.size()) begin failures++; $display("[TB] FAIL oor_writes got=%0d want=%0d", obs_addr.size(), exp_addr.size()); end
        checks++; if (done_cyc !== (exp_rej ? 1 : 2 + exp_addr.size())) begin failures++; $display("[TB] FAIL oor_done_cycle got=%0d want=%0d", done_cyc, exp_rej ? 1 : 2 + exp_addr.size()); end
        if (obs_addr.size() == 1 && exp_addr.size() == 1) begin
            checks++; if (obs_addr[0] !== exp_addr[0]) begin failures++; $display("[TB] FAIL oor_addr got=%0d want=%0d", obs_addr[0], exp_addr[0]); end
        end
    endtask

    task automatic test_random_fills;
        int ax0, ax1, ay0, ay1, w, h, kind, exp_done;
        logic [15:0] col;
        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 5);
            col = 16'($urandom);
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 6);
            ax0 = $urandom_range(0, H_RES - w); ax1 = ax0 + w - 1;
            ay0 = $urandom_range(0, V_RES - h); ay1 = ay0 + h - 1;
            if (kind == 0) begin
                ax0 = $urandom_range(1, H_RES - 1); ax1 = $urandom_range(0, ax0 - 1);
            end else if (kind == 1) begin
                ay0 = $urandom_range(1, V_RES - 1); ay1 = $urandom_range(0, ay0 - 1);
            end else if (kind == 2) begin
                ax0 = $urandom_range(600, 639); ax1 = $urandom_range(640, 1023);
            end
            model(ax0, ax1, ay0, ay1);
            exp_done = exp_rej ? 1 : 2 + exp_addr.size();
            send_cmd(ax0, ax1, ay0, ay1, col);
            collect(exp_done + 10);
            checks++;
            if (done_cyc !== exp_done || done_err !== exp_rej) begin
                failures++;
                $display("[TB] FAIL rand%0d_done got cyc=%0d err=%b want cyc=%0d err=%b (x %0d..%0d y %0d..%0d)",
                         n, done_cyc, done_err, exp_done, exp_rej, ax0, ax1, ay0, ay1);
            end
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                failures++;
                $display("[TB] FAIL rand%0d_count got=%0d want=%0d", n, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== col || obs_cyc[i] !== i + 2) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             n, i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], col, i + 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int wcyc[$];
        int dcyc[$];
        for (int i = 0; i < 1000 && cmd_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        x0 = 10'd100; x1 = 10'd101; y0 = 9'd50; y1 = 9'd50; color = 16'h5A5A;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (wea === 1'b1) wcyc.push_back(k);
            if (done === 1'b1) dcyc.push_back(k);
            if (k == 4) begin
                checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_in_done got=%b want=0", cmd_ready); end
            end
            if (k == 9) cmd_valid = 1'b0;
            if (k == 10) begin
                checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy); end
            end
        end
        checks++;
        if (wcyc.size() != 4 || wcyc[0] != 2 || wcyc[1] != 3 || wcyc[2] != 7 || wcyc[3] != 8) begin
            failures++;
            $display("[TB] FAIL b2b_write_cycles got=%p want='{2,3,7,8}", wcyc);
        end
        checks++;
        if (dcyc.size() != 2 || dcyc[0] != 4 || dcyc[1] != 9) begin
            failures++;
            $display("[TB] FAIL b2b_done_cycles got=%p want='{4,9}", dcyc);
        end
    endtask

    task automatic test_reset_midfill;
        for (int i = 0; i < 1000 && cmd_ready !== 1'b1; i++) @(negedge clk);
        send_cmd(20, 23, 10, 13, 16'hABCD);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        checks++; if (wea !== 1'b1 || addra !== 19'd6422) begin failures++; $display("[TB] FAIL mid_third_write got wea=%b addr=%0d want wea=1 addr=6422", wea, addra); end
        rstn = 1'b0;
        #1;
        checks++; if (wea !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_wea got=%b want=0", wea); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_done got=%b want=0", done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_ready got=%b want=1", cmd_ready); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        collect(3);
        checks++; if (done_count !== 0 || obs_addr.size() != 0) begin failures++; $display("[TB] FAIL mid_after_release got done=%0d writes=%0d want 0 0", done_count, obs_addr.size()); end
        send_cmd(7, 7, 2, 2, 16'h1234);
        collect(20);
        checks++;
        if (obs_addr.size() != 1 || done_cyc !== 3 || done_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_new_cmd got writes=%0d done_cyc=%0d err=%b want 1 3 0", obs_addr.size(), done_cyc, done_err);
        end else begin
            checks++; if (obs_addr[0] !== 1287 || obs_data[0] !== 16'h1234) begin failures++; $display("[TB] FAIL mid_new_write got addr=%0d data=%h want addr=1287 data=1234", obs_addr[0], obs_data[0]); end
        end
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_row_wrap;
        test_reject;
        test_corner_block;
        test_random_fills;
        test_back_to_back;
        test_reset_midfill;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
